rcv_bit_ctrl: RTL and testbench
===============================

Name: rcv_bit_ctrl

Overview:
- Receive-side bit-timing and framing controller for the asynchronous serial link.
- Synchronises the raw line, detects the start bit, and times mid-bit sampling.
- Drives the shift_enable and serial_in inputs of the downstream serial-to-parallel shift register, and checks the stop bit.
- Pulses a buffer load on each good frame and tracks data_ready / overrun for the consumer.

Parameters:
DATA_BITS, 8, data bits per frame (2..16)
CLKS_PER_BIT, 16, clk cycles per bit period (>=4)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
serial_in  input  1  raw line, idle high
data_read  input  1  consumer acknowledges buffered byte (1-cycle pulse)
serial_sync  output  1  synchronised line; feeds shift register serial_in
shift_strobe  output  1  1-cycle pulse; feeds shift register shift_enable
load_buffer  output  1  1-cycle pulse; shift register contents valid this cycle
data_ready  output  1  buffered frame pending
framing_error  output  1  stop bit sampled low
overrun_error  output  1  new frame loaded while data_ready still set

Behaviour:
- Reset is asynchronous and active-high. While in reset: state=IDLE, counters=0, both synchroniser flops=1, serial_sync=1, and all other outputs=0.
- Synchroniser: 2 flops. serial_sync is the second flop. A third flop, prev, holds the previous serial_sync value.
- Start edge: prev=1 and serial_sync=0, detected in IDLE. The FSM enters START_CHK next cycle with bit_timer=0.
- bit_timer counts 0..CLKS_PER_BIT-1; width is $clog2(CLKS_PER_BIT). bit_cnt counts data bits; width is $clog2(DATA_BITS+1).
- FSM states: IDLE, START_CHK, DATA, [PARITY], STOP, LOAD.
- START_CHK:
  - Waits until bit_timer == CLKS_PER_BIT/2 - 1 (floor division).
  - If serial_sync=0 there: go to DATA, bit_timer=0, bit_cnt=0.
  - Otherwise (glitch): go to IDLE, with no flags touched.
- DATA:
  - When bit_timer == CLKS_PER_BIT-1, assert shift_strobe for that cycle, bit_timer=0, bit_cnt++.
  - After the DATA_BITS-th strobe, go to STOP (or PARITY if enabled).
  - Sample points therefore land mid-bit.
- STOP:
  - At bit_timer == CLKS_PER_BIT-1, sample serial_sync.
  - 1: go to LOAD.
  - 0: set framing_error and go to IDLE (no load).
  - The IDLE entry edge detector re-arms only after a high is seen (prev logic).
- LOAD: assert load_buffer for 1 cycle and set data_ready. If data_ready was already 1 and data_read is not asserted this cycle, set overrun_error. Next state is IDLE.
- data_read clears data_ready.
  - data_read and load_buffer in the same cycle: data_ready stays 1, no overrun.
  - data_read while data_ready=0: no effect.
- framing_error and overrun_error are sticky. Both clear on the cycle START_CHK is confirmed (transition to DATA). overrun_error also clears on data_read.
- serial_in activity outside IDLE/START_CHK never restarts the FSM. Start detection only occurs in IDLE.
- rst asserted mid-frame: immediate return to reset values. A partial frame is discarded with no load_buffer.
- Throughput: back-to-back frames are supported. The IDLE → START_CHK edge can be taken the cycle after LOAD.

Optional Feature:
- Macro: RCV_PARITY_EN.
- Defined:
  - Adds a PARITY state after DATA.
  - Samples one bit at the end of a full bit period.
  - Running XOR over the sampled data bits, even parity: received parity must equal XOR of the data bits.
  - On mismatch, sets a sticky output parity_error. It clears with the same rules as framing_error.
  - The frame still proceeds to STOP and LOAD.
  - Parity bit is NOT strobed into the shift register.
- Undefined: no PARITY state, no parity_error port, frame = start + DATA_BITS + stop.

Decomposition:
- Package rcv_pkg holds:
  - enum rcv_state_t {IDLE, START_CHK, DATA, PARITY, STOP, LOAD};
  - localparam helper functions for timer/counter widths.
- One natural sub-module: rcv_bit_timer. It contains the bit_timer counter with clear, enable, half/full-period compare outputs, and rollover pulse.

Test Plan:
- CLKS_PER_BIT=16, DATA_BITS=8; send 0xA5 LSB-first with good stop → exactly 8 shift_strobe pulses spaced 16 cycles apart, then 1 load_buffer pulse; data_ready=1; no errors.
- Low glitch of 4 cycles on idle line → return to IDLE, zero shift_strobe, flags unchanged.
- Frame with stop bit low → framing_error=1, no load_buffer, data_ready unchanged; next good frame clears framing_error at START_CHK confirm.
- Two frames with no data_read in between → second LOAD sets overrun_error=1, data_ready=1; data_read then clears both.
- data_read asserted in the exact LOAD cycle of a second frame → data_ready stays 1, overrun_error stays 0.
- rst pulsed during bit 3 → all outputs return to 0 (serial_sync=1) immediately; a fresh frame afterwards receives correctly. With RCV_PARITY_EN: send 0x07 with parity 0 → parity_error=1, load_buffer still pulses.

Source files
------------

// File: rtl/rcv_pkg.sv
// rcv_pkg: shared types and width helpers for the serial receive controller.
//   rcv_state_t  - receive FSM states
//   timer_width  - width of the bit-period timer for a given CLKS_PER_BIT
//   count_width  - width of the data-bit counter for a given DATA_BITS
package rcv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        DATA,
        PARITY,
        STOP,
        LOAD
    } rcv_state_t;

    function automatic int unsigned timer_width(input int unsigned clks_per_bit);
        return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
    endfunction

    function automatic int unsigned count_width(input int unsigned data_bits);
        return $clog2(data_bits + 1);
    endfunction

endpackage

// File: rtl/rcv_bit_timer.sv
// rcv_bit_timer: bit-period counter for the receive controller.
//   clk, rst   - clock, asynchronous active-high reset
//   clear      - force the counter to 0 next cycle (wins over enable)
//   enable     - count this cycle; wraps to 0 after CLKS_PER_BIT-1
//   half_hit   - counter == CLKS_PER_BIT/2 - 1 (start-bit centre check)
//   full_hit   - counter == CLKS_PER_BIT - 1 (end of a bit period)
//   rollover   - full_hit while counting, i.e. the counter wraps this cycle
module rcv_bit_timer
    import rcv_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned TW           = timer_width(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic half_hit,
    output logic full_hit,
    output logic rollover
);

    localparam logic [TW-1:0] HalfVal = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FullVal = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] bit_timer_q, bit_timer_d;

    assign half_hit = (bit_timer_q == HalfVal);
    assign full_hit = (bit_timer_q == FullVal);
    assign rollover = enable & ~clear & full_hit;

    always_comb begin
        bit_timer_d = bit_timer_q;
        if (clear) begin
            bit_timer_d = '0;
        end else if (enable) begin
            bit_timer_d = full_hit ? '0 : bit_timer_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_timer_q <= '0;
        end else begin
            bit_timer_q <= bit_timer_d;
        end
    end

endmodule

// File: rtl/rcv_bit_ctrl.sv
// rcv_bit_ctrl: receive-side bit timing and framing for the async serial link.
//   clk, rst       - clock, asynchronous active-high reset
//   serial_in      - raw line, idle high
//   data_read      - consumer acknowledge of the buffered frame (1-cycle pulse)
//   serial_sync    - synchronised line, feeds the shift register data input
//   shift_strobe   - 1-cycle pulse at each data-bit centre, feeds shift enable
//   load_buffer    - 1-cycle pulse, shift register holds a good frame
//   data_ready     - buffered frame pending
//   framing_error  - sticky, stop bit sampled low
//   overrun_error  - sticky, frame loaded while data_ready still set
//   parity_error   - sticky, even-parity mismatch (only with RCV_PARITY_EN)
// Build option: define RCV_PARITY_EN to add a parity bit between data and stop.
module rcv_bit_ctrl
    import rcv_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic serial_in,
    input  logic data_read,
    output logic serial_sync,
    output logic shift_strobe,
    output logic load_buffer,
    output logic data_ready,
    output logic framing_error,
`ifdef RCV_PARITY_EN
    output logic overrun_error,
    output logic parity_error
`else
    output logic overrun_error
`endif
);

    localparam int unsigned   CW      = count_width(DATA_BITS);
    localparam logic [CW-1:0] LastBit = CW'(DATA_BITS - 1);

    rcv_state_t    state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic          sync1_q, sync2_q, prev_q;
    logic          data_ready_q, data_ready_d;
    logic          framing_q, framing_d;
    logic          overrun_q, overrun_d;
`ifdef RCV_PARITY_EN
    logic          parity_acc_q, parity_acc_d;
    logic          parity_err_q, parity_err_d;
`endif

    logic timer_clear, timer_en;
    logic half_hit, full_hit, rollover;

    rcv_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .enable   (timer_en),
        .half_hit (half_hit),
        .full_hit (full_hit),
        .rollover (rollover)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        data_ready_d = data_ready_q;
        framing_d    = framing_q;
        overrun_d    = overrun_q;
`ifdef RCV_PARITY_EN
        parity_acc_d = parity_acc_q;
        parity_err_d = parity_err_q;
`endif
        timer_clear  = 1'b0;
        timer_en     = 1'b0;
        shift_strobe = 1'b0;
        load_buffer  = 1'b0;

        unique case (state_q)
            IDLE: begin
                timer_clear = 1'b1;
                // prev_q only returns high after the line does, so a low stop bit
                // cannot be mistaken for the next start edge.
                if (prev_q && !sync2_q) begin
                    state_d = START_CHK;
                end
            end
            START_CHK: begin
                timer_en = 1'b1;
                if (half_hit) begin
                    if (!sync2_q) begin
                        state_d     = DATA;
                        timer_clear = 1'b1;
                        bit_cnt_d   = '0;
                        framing_d   = 1'b0;
                        overrun_d   = 1'b0;
`ifdef RCV_PARITY_EN
                        parity_acc_d = 1'b0;
                        parity_err_d = 1'b0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                timer_en = 1'b1;
                if (rollover) begin
                    shift_strobe = 1'b1;
                    bit_cnt_d    = bit_cnt_q + CW'(1);
`ifdef RCV_PARITY_EN
                    parity_acc_d = parity_acc_q ^ sync2_q;
                    if (bit_cnt_q == LastBit) state_d = PARITY;
`else
                    if (bit_cnt_q == LastBit) state_d = STOP;
`endif
                end
            end
`ifdef RCV_PARITY_EN
            PARITY: begin
                timer_en = 1'b1;
                if (full_hit) begin
                    if (sync2_q != parity_acc_q) parity_err_d = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                timer_en = 1'b1;
                if (full_hit) begin
                    if (sync2_q) begin
                        state_d = LOAD;
                    end else begin
                        framing_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            LOAD: begin
                timer_clear = 1'b1;
                load_buffer = 1'b1;
                state_d     = IDLE;
                if (data_ready_q && !data_read) overrun_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A read coinciding with a load leaves the new frame pending.
        if (data_read) begin
            data_ready_d = 1'b0;
            overrun_d    = 1'b0;
        end
        if (load_buffer) data_ready_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            prev_q       <= 1'b1;
            data_ready_q <= 1'b0;
            framing_q    <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef RCV_PARITY_EN
            parity_acc_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            sync1_q      <= serial_in;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            data_ready_q <= data_ready_d;
            framing_q    <= framing_d;
            overrun_q    <= overrun_d;
`ifdef RCV_PARITY_EN
            parity_acc_q <= parity_acc_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign serial_sync   = sync2_q;
    assign data_ready    = data_ready_q;
    assign framing_error = framing_q;
    assign overrun_error = overrun_q;
`ifdef RCV_PARITY_EN
    assign parity_error  = parity_err_q;
`endif

endmodule

// File: tb/tb_rcv_bit_ctrl.sv
// tb_rcv_bit_ctrl: self-checking bench for rcv_bit_ctrl (DATA_BITS=8, CLKS_PER_BIT=16).
// Expected frames are queued as they are transmitted; a monitor rebuilds each
// received word from serial_sync/shift_strobe and queues it on load_buffer.
module tb_rcv_bit_ctrl;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned CLKS      = 16;

    typedef struct {
        logic [7:0] word;
        int         nstr;
        bit         gaps_ok;
    } obs_t;

    logic clk = 1'b0;
    logic rst, serial_in, data_read;
    logic serial_sync, shift_strobe, load_buffer, data_ready, framing_error, overrun_error;
`ifdef RCV_PARITY_EN
    logic parity_error;
`endif

    logic [7:0] exp_q[$];
    obs_t       obs_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         total_strobes = 0;

    always #5 clk = ~clk;

    rcv_bit_ctrl #(
        .DATA_BITS    (DATA_BITS),
        .CLKS_PER_BIT (CLKS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .data_read     (data_read),
        .serial_sync   (serial_sync),
        .shift_strobe  (shift_strobe),
        .load_buffer   (load_buffer),
        .data_ready    (data_ready),
        .framing_error (framing_error),
`ifdef RCV_PARITY_EN
        .overrun_error (overrun_error),
        .parity_error  (parity_error)
`else
        .overrun_error (overrun_error)
`endif
    );

    // Monitor: downstream shift register model plus strobe spacing tracking.
    initial begin
        int         cycle = 0;
        int         last_strobe = -1000;
        int         nstr = 0;
        bit         gaps_ok = 1'b1;
        logic [7:0] shreg = 8'h00;
        forever begin
            @(negedge clk);
            cycle++;
            if (rst) begin
                nstr    = 0;
                gaps_ok = 1'b1;
            end else begin
                if (shift_strobe) begin
                    total_strobes++;
                    if (nstr == 0 || cycle - last_strobe > 2 * CLKS) begin
                        nstr    = 0;
                        gaps_ok = 1'b1;
                    end else if (cycle - last_strobe != CLKS) begin
                        gaps_ok = 1'b0;
                    end
                    nstr++;
                    last_strobe = cycle;
                    shreg = {serial_sync, shreg[7:1]};
                end
                if (load_buffer) begin
                    obs_q.push_back('{shreg, nstr, gaps_ok});
                    nstr    = 0;
                    gaps_ok = 1'b1;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    // One bit period on the line; optionally acknowledges in the LOAD cycle.
    task automatic drive_bit(input logic v, input bit read_on_load);
        serial_in = v;
        for (int i = 0; i < int'(CLKS); i++) begin
            @(negedge clk);
            if (data_read) data_read = 1'b0;
            else if (read_on_load && load_buffer) data_read = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit par_ok,
                              input bit read_on_load);
        if (stop_bit) exp_q.push_back(d);
        drive_bit(1'b0, read_on_load);
        for (int i = 0; i < int'(DATA_BITS); i++) drive_bit(d[i], read_on_load);
`ifdef RCV_PARITY_EN
        drive_bit((^d) ^ ~par_ok, read_on_load);
`else
        if (!par_ok) $display("note: parity request ignored without parity build");
`endif
        drive_bit(stop_bit, read_on_load);
        serial_in = 1'b1;
        if (data_read) begin
            @(negedge clk);
            data_read = 1'b0;
        end
    endtask

    task automatic pop_frame(output obs_t o, output logic [7:0] e, output bit got);
        int n = 0;
        while (obs_q.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        got = (obs_q.size() != 0) && (exp_q.size() != 0);
        if (got) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
        end else begin
            o = '{8'h00, 0, 1'b0};
            e = 8'h00;
        end
    endtask

    task automatic pulse_read();
        @(negedge clk);
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; serial_in = 1'b1; data_read = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (serial_sync !== 1'b1) begin miscompares++; $display("FAIL reset_sync: got %b want 1", serial_sync); end
        vectors++; if (shift_strobe !== 1'b0) begin miscompares++; $display("FAIL reset_strobe: got %b want 0", shift_strobe); end
        vectors++; if (load_buffer !== 1'b0) begin miscompares++; $display("FAIL reset_load: got %b want 0", load_buffer); end
        vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", data_ready); end
        vectors++; if ({framing_error, overrun_error} !== 2'b00) begin miscompares++; $display("FAIL reset_errors: got %b want 00", {framing_error, overrun_error}); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_good_frame();
        obs_t o; logic [7:0] e; bit got; int s0;
        s0 = total_strobes;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        pop_frame(o, e, got);
        vectors++; if (!got) begin miscompares++; $display("FAIL good_load: got no load want one load"); end
        else begin
            vectors++; if (o.word !== e) begin miscompares++; $display("FAIL good_word: got %h want %h", o.word, e); end
            vectors++; if (o.nstr != 8) begin miscompares++; $display("FAIL good_nstrobe: got %0d want 8", o.nstr); end
            vectors++; if (!o.gaps_ok) begin miscompares++; $display("FAIL good_spacing: got irregular want %0d-cycle gaps", CLKS); end
        end
        vectors++; if (total_strobes - s0 != 8) begin miscompares++; $display("FAIL good_strobes: got %0d want 8", total_strobes - s0); end
        vectors++; if (data_ready !== 1'b1) begin miscompares++; $display("FAIL good_ready: got %b want 1", data_ready); end
        vectors++; if ({framing_error, overrun_error} !== 2'b00) begin miscompares++; $display("FAIL good_errors: got %b want 00", {framing_error, overrun_error}); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_glitch();
        int s0;
        s0 = total_strobes;
        serial_in = 1'b0;
        repeat (4) @(negedge clk);
        serial_in = 1'b1;
        repeat (40) @(negedge clk);
        vectors++; if (total_strobes != s0) begin miscompares++; $display("FAIL glitch_strobes: got %0d want 0", total_strobes - s0); end
        vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL glitch_load: got %0d loads want 0", obs_q.size()); end
        vectors++; if ({data_ready, framing_error, overrun_error} !== 3'b100) begin miscompares++; $display("FAIL glitch_flags: got %b want 100", {data_ready, framing_error, overrun_error}); end
        pulse_read();
        vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL read_clear: got %b want 0", data_ready); end
    endtask

    task automatic test_framing();
        obs_t o; logic [7:0] e; bit got; int s0;
        s0 = total_strobes;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        vectors++; if (framing_error !== 1'b1) begin miscompares++; $display("FAIL framing_set: got %b want 1", framing_error); end
        vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL framing_noload: got %0d loads want 0", obs_q.size()); end
        vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL framing_ready: got %b want 0", data_ready); end
        vectors++; if (total_strobes - s0 != 8) begin miscompares++; $display("FAIL framing_strobes: got %0d want 8", total_strobes - s0); end
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        pop_frame(o, e, got);
        vectors++; if (!got || o.word !== e) begin miscompares++; $display("FAIL framing_next_word: got %h want %h", o.word, e); end
        vectors++; if (framing_error !== 1'b0) begin miscompares++; $display("FAIL framing_clear: got %b want 0", framing_error); end
        pulse_read();
    endtask

    task automatic test_back_to_back();
        obs_t o; logic [7:0] e; bit got;
        send_frame(8'h11, 1'b1, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            pop_frame(o, e, got);
            vectors++; if (!got || o.word !== e || o.nstr != 8) begin miscompares++; $display("FAIL b2b_word%0d: got %h/%0d want %h/8", k, o.word, o.nstr, e); end
        end
        vectors++; if ({data_ready, overrun_error} !== 2'b11) begin miscompares++; $display("FAIL overrun_set: got %b want 11", {data_ready, overrun_error}); end
        pulse_read();
        vectors++; if ({data_ready, overrun_error} !== 2'b00) begin miscompares++; $display("FAIL overrun_clear: got %b want 00", {data_ready, overrun_error}); end
    endtask

    task automatic test_read_on_load();
        obs_t o; logic [7:0] e; bit got;
        send_frame(8'h33, 1'b1, 1'b1, 1'b0);
        send_frame(8'h44, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            pop_frame(o, e, got);
            vectors++; if (!got || o.word !== e) begin miscompares++; $display("FAIL rol_word%0d: got %h want %h", k, o.word, e); end
        end
        vectors++; if ({data_ready, overrun_error} !== 2'b10) begin miscompares++; $display("FAIL rol_flags: got %b want 10", {data_ready, overrun_error}); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        obs_t o; logic [7:0] e; bit got;
        logic [7:0] d;
        d = 8'hF0;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i], 1'b0);
        serial_in = d[3];
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++; if (serial_sync !== 1'b1) begin miscompares++; $display("FAIL midrst_sync: got %b want 1", serial_sync); end
        vectors++; if ({shift_strobe, load_buffer, data_ready, framing_error, overrun_error} !== 5'b0) begin
            miscompares++; $display("FAIL midrst_outputs: got %b want 00000", {shift_strobe, load_buffer, data_ready, framing_error, overrun_error}); end
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL midrst_noload: got %0d loads want 0", obs_q.size()); end
        send_frame(8'hC3, 1'b1, 1'b1, 1'b0);
        pop_frame(o, e, got);
        vectors++; if (!got || o.word !== e || o.nstr != 8) begin miscompares++; $display("FAIL midrst_fresh: got %h/%0d want %h/8", o.word, o.nstr, e); end
        vectors++; if (data_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b want 1", data_ready); end
        pulse_read();
    endtask

`ifdef RCV_PARITY_EN
    task automatic test_parity();
        obs_t o; logic [7:0] e; bit got;
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        pop_frame(o, e, got);
        vectors++; if (!got || o.word !== e || o.nstr != 8) begin miscompares++; $display("FAIL parity_load: got %h/%0d want %h/8", o.word, o.nstr, e); end
        vectors++; if (parity_error !== 1'b1) begin miscompares++; $display("FAIL parity_set: got %b want 1", parity_error); end
        pulse_read();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        pop_frame(o, e, got);
        vectors++; if (parity_error !== 1'b0) begin miscompares++; $display("FAIL parity_clear: got %b want 0", parity_error); end
        pulse_read();
    endtask
`endif

    initial begin
        test_reset();
        test_good_frame();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_read_on_load();
        test_reset_mid();
`ifdef RCV_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
